// File: rtl/vga_pkg.sv
// Shared VGA types: video modes, Line states, per-axis timing, and the
// sequencing controller's state encoding.
package vga_pkg;

    localparam int LINE_WIDTH = 12;

    typedef enum logic [1:0] {
        VGA_640x480_60  = 2'd0,
        VGA_800x600_60  = 2'd1,
        VGA_1024x768_60 = 2'd2
    } VGA_mode_e;

    typedef enum logic [1:0] {
        VGA_VISIBLE     = 2'd0,
        VGA_FRONT_PORCH = 2'd1,
        VGA_SYNC        = 2'd2,
        VGA_BACK_PORCH  = 2'd3
    } VGA_state_e;

    typedef struct packed {
        logic [LINE_WIDTH-1:0] visible_area;
        logic [LINE_WIDTH-1:0] front_porch;
        logic [LINE_WIDTH-1:0] sync_pulse;
        logic [LINE_WIDTH-1:0] back_porch;
        logic                  polarity;
    } line_t;

    typedef struct packed {
        line_t h;
        line_t v;
    } vga_timing_t;

    typedef enum logic [1:0] {
        CTRL_RELOAD = 2'd0,
        CTRL_WARMUP = 2'd1,
        CTRL_RUN    = 2'd2,
        CTRL_DRAIN  = 2'd3
    } ctrl_state_e;

    function automatic line_t mk_line(input int va, input int fp, input int sp,
                                      input int bp, input logic pol);
        line_t l;
        l.visible_area = LINE_WIDTH'(va);
        l.front_porch  = LINE_WIDTH'(fp);
        l.sync_pulse   = LINE_WIDTH'(sp);
        l.back_porch   = LINE_WIDTH'(bp);
        l.polarity     = pol;
        return l;
    endfunction

    // Unknown encodings fall back to 640x480 so the Lines always get a sane frame.
    function automatic vga_timing_t get_vga_timing(input VGA_mode_e mode);
        vga_timing_t t;
        case (mode)
            VGA_800x600_60: begin
                t.h = mk_line(800, 40, 128, 88, 1'b1);
                t.v = mk_line(600, 1, 4, 23, 1'b1);
            end
            VGA_1024x768_60: begin
                t.h = mk_line(1024, 24, 136, 160, 1'b0);
                t.v = mk_line(768, 3, 6, 29, 1'b0);
            end
            default: begin
                t.h = mk_line(640, 16, 96, 48, 1'b0);
                t.v = mk_line(480, 10, 2, 33, 1'b0);
            end
        endcase
        return t;
    endfunction

    function automatic logic [LINE_WIDTH:0] line_total(input line_t l);
        return {1'b0, l.visible_area} + {1'b0, l.front_porch} +
               {1'b0, l.sync_pulse} + {1'b0, l.back_porch};
    endfunction

endpackage

// File: rtl/vga_frame_edge.sv
// Tracks the previous vertical Line state and flags start-of-frame and
// start-of-vertical-blanking edges.
module vga_frame_edge
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       line_rstn,
    input  VGA_state_e v_state,
    output logic       sof_int,
    output logic       vbs_int,
    output logic       sof
);

    VGA_state_e prev_v_q, prev_v_d;
    logic       sof_q, sof_d;

    // Holding prev at visible while the Lines are in reset hides the
    // restart itself from the edge detectors.
    always_comb begin
        prev_v_d = line_rstn ? v_state : VGA_VISIBLE;
        sof_int  = (v_state == VGA_VISIBLE) && (prev_v_q != VGA_VISIBLE);
        vbs_int  = (v_state != VGA_VISIBLE) && (prev_v_q == VGA_VISIBLE);
        sof_d    = sof_int;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            prev_v_q <= VGA_VISIBLE;
            sof_q    <= 1'b0;
        end else begin
            prev_v_q <= prev_v_d;
            sof_q    <= sof_d;
        end
    end

    assign sof = sof_q;

endmodule

// File: rtl/vga_mode_ctrl.sv
// Owns the h/v Line timing and reset; switches video modes at vertical
// blanking and gates video_en until the restarted Lines have settled.
module vga_mode_ctrl
    import vga_pkg::*;
#(
    parameter int        LINE_WIDTH    = vga_pkg::LINE_WIDTH,
    parameter VGA_mode_e DEFAULT_MODE  = VGA_640x480_60,
    parameter int        RELOAD_CYCLES = 4,
    parameter int        WARMUP_FRAMES = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  VGA_mode_e  mode_req,
    input  logic       mode_req_valid,
    output logic       mode_req_ready,
    input  VGA_state_e h_state,
    input  VGA_state_e v_state,
    output line_t      h_cfg,
    output line_t      v_cfg,
    output logic       line_rstn,
    output VGA_mode_e  cur_mode,
    output logic       video_en,
    output logic       sof,
    output logic       busy
);

    localparam int RCW = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
    localparam int FCW = $clog2(WARMUP_FRAMES + 1);
    localparam logic [RCW-1:0] RLD_INIT = RCW'(RELOAD_CYCLES - 1);
    localparam vga_timing_t DEF_TIMING = get_vga_timing(DEFAULT_MODE);

    if (LINE_WIDTH != vga_pkg::LINE_WIDTH || RELOAD_CYCLES < 1 || WARMUP_FRAMES < 1) begin : g_param_check
        $error("vga_mode_ctrl: illegal parameter combination");
    end

    ctrl_state_e    state_q, state_d;
    logic [RCW-1:0] rld_cnt_q, rld_cnt_d;
    logic [FCW-1:0] frm_cnt_q, frm_cnt_d, frm_inc;
    VGA_mode_e      pend_q, pend_d;
    VGA_mode_e      cur_mode_q, cur_mode_d;
    line_t          h_cfg_q, h_cfg_d, v_cfg_q, v_cfg_d;
    logic           line_rstn_q, line_rstn_d;
    logic           video_en_q, video_en_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    vga_timing_t    new_timing;
    logic           sof_int, vbs_int;

    vga_frame_edge u_frame_edge (
        .clk       (clk),
        .rstn      (rstn),
        .line_rstn (line_rstn_q),
        .v_state   (v_state),
        .sof_int   (sof_int),
        .vbs_int   (vbs_int),
        .sof       (sof)
    );

    always_comb begin
        state_d     = state_q;
        rld_cnt_d   = rld_cnt_q;
        frm_cnt_d   = frm_cnt_q;
        pend_d      = pend_q;
        cur_mode_d  = cur_mode_q;
        h_cfg_d     = h_cfg_q;
        v_cfg_d     = v_cfg_q;
        line_rstn_d = line_rstn_q;
        video_en_d  = video_en_q;
        frm_inc     = frm_cnt_q + 1'b1;
        new_timing  = get_vga_timing(pend_q);

        case (state_q)
            CTRL_RELOAD: begin
                if (rld_cnt_q == '0) begin
                    state_d     = CTRL_WARMUP;
                    line_rstn_d = 1'b1;
                    frm_cnt_d   = '0;
                end else begin
                    rld_cnt_d = rld_cnt_q - 1'b1;
                end
            end
            CTRL_WARMUP: begin
                if (sof_int) begin
                    frm_cnt_d = frm_inc;
                    if (frm_inc == FCW'(WARMUP_FRAMES)) begin
                        state_d    = CTRL_RUN;
                        video_en_d = 1'b1;
                    end
                end
            end
            CTRL_RUN: begin
                // Re-requesting the active mode completes the handshake with no restart.
                if (mode_req_valid && ready_q && (mode_req != cur_mode_q)) begin
                    pend_d  = mode_req;
                    state_d = CTRL_DRAIN;
                end
            end
            CTRL_DRAIN: begin
                if (vbs_int) begin
                    state_d     = CTRL_RELOAD;
                    cur_mode_d  = pend_q;
                    h_cfg_d     = new_timing.h;
                    v_cfg_d     = new_timing.v;
                    video_en_d  = 1'b0;
                    line_rstn_d = 1'b0;
                    rld_cnt_d   = RLD_INIT;
                end
            end
            default: state_d = CTRL_RELOAD;
        endcase

        ready_d = (state_d == CTRL_RUN);
        busy_d  = (state_d != CTRL_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= CTRL_RELOAD;
            rld_cnt_q   <= RLD_INIT;
            frm_cnt_q   <= '0;
            pend_q      <= DEFAULT_MODE;
            cur_mode_q  <= DEFAULT_MODE;
            h_cfg_q     <= DEF_TIMING.h;
            v_cfg_q     <= DEF_TIMING.v;
            line_rstn_q <= 1'b0;
            video_en_q  <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            rld_cnt_q   <= rld_cnt_d;
            frm_cnt_q   <= frm_cnt_d;
            pend_q      <= pend_d;
            cur_mode_q  <= cur_mode_d;
            h_cfg_q     <= h_cfg_d;
            v_cfg_q     <= v_cfg_d;
            line_rstn_q <= line_rstn_d;
            video_en_q  <= video_en_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign mode_req_ready = ready_q;
    assign busy           = busy_q;
    assign line_rstn      = line_rstn_q;
    assign video_en       = video_en_q;
    assign cur_mode       = cur_mode_q;
    assign h_cfg          = h_cfg_q;
    assign v_cfg          = v_cfg_q;

`ifndef SYNTHESIS
    a_h_visible_on_sof: assert property (@(posedge clk) disable iff (!rstn)
        sof_int |-> (h_state == VGA_VISIBLE));
`endif

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl; a toy vertical Line with a 20-cycle frame
// stands in for the real generator so whole frames stay short.
module tb_vga_mode_ctrl;
    import vga_pkg::*;

    localparam int VIS   = 12;
    localparam int FP    = 2;
    localparam int SP    = 2;
    localparam int BP    = 4;
    localparam int FRAME = VIS + FP + SP + BP;

    localparam line_t H640  = '{visible_area: 12'd640,  front_porch: 12'd16, sync_pulse: 12'd96,  back_porch: 12'd48,  polarity: 1'b0};
    localparam line_t V640  = '{visible_area: 12'd480,  front_porch: 12'd10, sync_pulse: 12'd2,   back_porch: 12'd33,  polarity: 1'b0};
    localparam line_t H800  = '{visible_area: 12'd800,  front_porch: 12'd40, sync_pulse: 12'd128, back_porch: 12'd88,  polarity: 1'b1};
    localparam line_t V800  = '{visible_area: 12'd600,  front_porch: 12'd1,  sync_pulse: 12'd4,   back_porch: 12'd23,  polarity: 1'b1};
    localparam line_t H1024 = '{visible_area: 12'd1024, front_porch: 12'd24, sync_pulse: 12'd136, back_porch: 12'd160, polarity: 1'b0};
    localparam line_t V1024 = '{visible_area: 12'd768,  front_porch: 12'd3,  sync_pulse: 12'd6,   back_porch: 12'd29,  polarity: 1'b0};

    logic       clk;
    logic       rstn;
    VGA_mode_e  mode_req;
    logic       mode_req_valid;
    VGA_state_e h_state;
    VGA_state_e v_state_a, v_state_b;

    logic       ready_a, line_rstn_a, video_en_a, sof_a, busy_a;
    line_t      h_cfg_a, v_cfg_a;
    VGA_mode_e  cur_mode_a;

    logic       ready_b, line_rstn_b, video_en_b, sof_b, busy_b;
    line_t      h_cfg_b, v_cfg_b;
    VGA_mode_e  cur_mode_b;

    int n_checks;
    int n_fail;
    int pos_a, pos_b;

    vga_mode_ctrl dut (
        .clk (clk), .rstn (rstn),
        .mode_req (mode_req), .mode_req_valid (mode_req_valid), .mode_req_ready (ready_a),
        .h_state (h_state), .v_state (v_state_a),
        .h_cfg (h_cfg_a), .v_cfg (v_cfg_a), .line_rstn (line_rstn_a),
        .cur_mode (cur_mode_a), .video_en (video_en_a), .sof (sof_a), .busy (busy_a)
    );

    vga_mode_ctrl #(.WARMUP_FRAMES(3)) dut_w3 (
        .clk (clk), .rstn (rstn),
        .mode_req (VGA_640x480_60), .mode_req_valid (1'b0), .mode_req_ready (ready_b),
        .h_state (h_state), .v_state (v_state_b),
        .h_cfg (h_cfg_b), .v_cfg (v_cfg_b), .line_rstn (line_rstn_b),
        .cur_mode (cur_mode_b), .video_en (video_en_b), .sof (sof_b), .busy (busy_b)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- toy vertical Line models ----------------
    function automatic VGA_state_e toy_state(input int p);
        if (p < VIS)           return VGA_VISIBLE;
        if (p < VIS + FP)      return VGA_FRONT_PORCH;
        if (p < VIS + FP + SP) return VGA_SYNC;
        return VGA_BACK_PORCH;
    endfunction

    initial begin
        pos_a     = 0;
        pos_b     = 0;
        h_state   = VGA_VISIBLE;
        v_state_a = VGA_VISIBLE;
        v_state_b = VGA_VISIBLE;
        forever begin
            @(negedge clk);
            pos_a     = (line_rstn_a !== 1'b1) ? 0 : ((pos_a == FRAME - 1) ? 0 : pos_a + 1);
            pos_b     = (line_rstn_b !== 1'b1) ? 0 : ((pos_b == FRAME - 1) ? 0 : pos_b + 1);
            v_state_a = toy_state(pos_a);
            v_state_b = toy_state(pos_b);
        end
    end

    // ---------------- driver tasks ----------------
    // All bench actions happen just after the falling edge: outputs are settled
    // and the Line model has already advanced.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_run(input string name);
        int n;
        n = 0;
        while (!(video_en_a === 1'b1 && ready_a === 1'b1) && n < 4 * FRAME) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= 4 * FRAME) begin
            n_fail++;
            $display("FAIL %s: timeout waiting for RUN, video_en=%b ready=%b required 1/1", name, video_en_a, ready_a);
        end
    endtask

    task automatic wait_pos(input string name, input int p);
        int n;
        n = 0;
        while (!(ready_a === 1'b1 && pos_a == p) && n < 3 * FRAME) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= 3 * FRAME) begin
            n_fail++;
            $display("FAIL %s: timeout waiting for line pos %0d with ready, got pos %0d ready=%b", name, p, pos_a, ready_a);
        end
    endtask

    task automatic request(input VGA_mode_e m);
        mode_req       = m;
        mode_req_valid = 1'b1;
        tick();
        mode_req_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n, early;
        rstn = 1'b0;
        mode_req_valid = 1'b0;
        mode_req = VGA_640x480_60;
        repeat (3) tick();
        n_checks++; if (line_rstn_a !== 1'b0) begin n_fail++; $display("FAIL rst_line_rstn: got %b required 0", line_rstn_a); end
        n_checks++; if (video_en_a !== 1'b0) begin n_fail++; $display("FAIL rst_video_en: got %b required 0", video_en_a); end
        n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b required 0", ready_a); end
        n_checks++; if (sof_a !== 1'b0) begin n_fail++; $display("FAIL rst_sof: got %b required 0", sof_a); end
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b required 1", busy_a); end
        n_checks++; if (cur_mode_a !== VGA_640x480_60) begin n_fail++; $display("FAIL rst_cur_mode: got %0d required 0", cur_mode_a); end
        n_checks++; if (h_cfg_a !== H640) begin n_fail++; $display("FAIL rst_h_cfg: got %h required %h", h_cfg_a, H640); end
        n_checks++; if (v_cfg_a !== V640) begin n_fail++; $display("FAIL rst_v_cfg: got %h required %h", v_cfg_a, V640); end

        rstn = 1'b1;
        n = 0;
        while (line_rstn_a === 1'b0 && n < 50) begin
            n++;
            tick();
        end
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL startup_line_rstn_low: got %0d cycles required 4", n); end

        // The Line restarts in visible, so the first sof is one full frame later.
        n = 0;
        early = 0;
        while (sof_a !== 1'b1 && n < 5 * FRAME) begin
            if (video_en_a !== 1'b0) early++;
            tick();
            n++;
        end
        n_checks++; if (n != FRAME) begin n_fail++; $display("FAIL first_sof_delay: got %0d cycles required %0d", n, FRAME); end
        n_checks++; if (early != 0) begin n_fail++; $display("FAIL video_en_before_sof: got %0d cycles high required 0", early); end
        // sof is sof_int registered, so it rises together with video_en.
        n_checks++; if (video_en_a !== 1'b1) begin n_fail++; $display("FAIL video_en_at_sof: got %b required 1", video_en_a); end
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL ready_after_warmup: got %b required 1", ready_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL busy_after_warmup: got %b required 0", busy_a); end
        tick();
        n_checks++; if (sof_a !== 1'b0) begin n_fail++; $display("FAIL sof_width: got %b required 0", sof_a); end
    endtask

    task automatic test_same_mode();
        int bad;
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL same_ready: got %b required 1", ready_a); end
        request(VGA_640x480_60);
        bad = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (line_rstn_a !== 1'b1 || video_en_a !== 1'b1 || busy_a !== 1'b0 || ready_a !== 1'b1) bad++;
            tick();
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL same_mode_disturbed: got %0d bad cycles required 0", bad); end
        n_checks++; if (cur_mode_a !== VGA_640x480_60) begin n_fail++; $display("FAIL same_mode_cur: got %0d required 0", cur_mode_a); end
    endtask

    task automatic test_mode_change();
        int n, drop;
        wait_pos("chg_align", 5);
        request(VGA_800x600_60);
        n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL chg_ready_drop: got %b required 0", ready_a); end
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL chg_busy: got %b required 1", busy_a); end
        n = 1;
        drop = 0;
        while (line_rstn_a === 1'b1 && n < 5 * FRAME) begin
            if (video_en_a !== 1'b1) drop++;
            tick();
            n++;
        end
        // Request at pos 5; the vbs cycle is pos 12, reload is visible one cycle after it.
        n_checks++; if (n != VIS - 5 + 1) begin n_fail++; $display("FAIL chg_switch_delay: got %0d required %0d", n, VIS - 5 + 1); end
        n_checks++; if (drop != 0) begin n_fail++; $display("FAIL chg_video_en_held: got %0d low cycles required 0", drop); end
        n_checks++; if (video_en_a !== 1'b0) begin n_fail++; $display("FAIL chg_video_en_off: got %b required 0", video_en_a); end
        n_checks++; if (cur_mode_a !== VGA_800x600_60) begin n_fail++; $display("FAIL chg_cur_mode: got %0d required 1", cur_mode_a); end
        n_checks++; if (h_cfg_a !== H800) begin n_fail++; $display("FAIL chg_h_cfg: got %h required %h", h_cfg_a, H800); end
        n_checks++; if (v_cfg_a !== V800) begin n_fail++; $display("FAIL chg_v_cfg: got %h required %h", v_cfg_a, V800); end
        n = 0;
        while (line_rstn_a === 1'b0 && n < 50) begin
            n++;
            tick();
        end
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL chg_line_rstn_low: got %0d cycles required 4", n); end
        wait_run("chg_rerun");
    endtask

    task automatic test_vbs_request();
        int n, drop;
        wait_pos("vbs_align", VIS);
        request(VGA_1024x768_60);
        n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL vbs_ready_drop: got %b required 0", ready_a); end
        n = 1;
        drop = 0;
        while (line_rstn_a === 1'b1 && n < 5 * FRAME) begin
            if (video_en_a !== 1'b1) drop++;
            tick();
            n++;
        end
        // The vbs in the handshake cycle is skipped; the next one is a full frame later.
        n_checks++; if (n != FRAME + 1) begin n_fail++; $display("FAIL vbs_switch_delay: got %0d required %0d", n, FRAME + 1); end
        n_checks++; if (drop != 0) begin n_fail++; $display("FAIL vbs_video_en_held: got %0d low cycles required 0", drop); end
        n_checks++; if (cur_mode_a !== VGA_1024x768_60) begin n_fail++; $display("FAIL vbs_cur_mode: got %0d required 2", cur_mode_a); end
        n_checks++; if (h_cfg_a !== H1024) begin n_fail++; $display("FAIL vbs_h_cfg: got %h required %h", h_cfg_a, H1024); end
        n_checks++; if (v_cfg_a !== V1024) begin n_fail++; $display("FAIL vbs_v_cfg: got %h required %h", v_cfg_a, V1024); end
        wait_run("vbs_rerun");
    endtask

    task automatic test_unknown_mode();
        int n;
        logic [1:0] raw;
        raw = 2'd3;
        wait_pos("unk_align", 3);
        request(VGA_mode_e'(raw));
        n = 0;
        while (line_rstn_a === 1'b1 && n < 3 * FRAME) begin
            tick();
            n++;
        end
        n_checks++; if (cur_mode_a !== raw) begin n_fail++; $display("FAIL unk_cur_mode: got %0d required 3", cur_mode_a); end
        n_checks++; if (h_cfg_a !== H640) begin n_fail++; $display("FAIL unk_h_cfg: got %h required %h", h_cfg_a, H640); end
        n_checks++; if (v_cfg_a !== V640) begin n_fail++; $display("FAIL unk_v_cfg: got %h required %h", v_cfg_a, V640); end
        wait_run("unk_rerun");
    endtask

    task automatic test_reset_in_drain();
        int bad;
        wait_pos("drn_align", 2);
        request(VGA_800x600_60);
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL drn_in_drain: got busy %b required 1", busy_a); end
        tick();
        rstn = 1'b0;
        tick();
        n_checks++; if (cur_mode_a !== VGA_640x480_60) begin n_fail++; $display("FAIL drn_cur_mode: got %0d required 0", cur_mode_a); end
        n_checks++; if (h_cfg_a !== H640) begin n_fail++; $display("FAIL drn_h_cfg: got %h required %h", h_cfg_a, H640); end
        n_checks++; if (line_rstn_a !== 1'b0) begin n_fail++; $display("FAIL drn_line_rstn: got %b required 0", line_rstn_a); end
        n_checks++; if (video_en_a !== 1'b0) begin n_fail++; $display("FAIL drn_video_en: got %b required 0", video_en_a); end
        n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL drn_ready: got %b required 0", ready_a); end
        rstn = 1'b1;
        wait_run("drn_rerun");
        bad = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (line_rstn_a !== 1'b1 || cur_mode_a !== VGA_640x480_60) bad++;
            tick();
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL drn_pending_discarded: got %0d bad cycles required 0", bad); end
    endtask

    task automatic test_reset_in_warmup();
        int n;
        wait_pos("wrm_align", 4);
        request(VGA_800x600_60);
        n = 0;
        while (line_rstn_a !== 1'b0 && n < 3 * FRAME) begin tick(); n++; end
        n = 0;
        while (line_rstn_a !== 1'b1 && n < 20) begin tick(); n++; end
        repeat (3) tick();
        n_checks++; if (busy_a !== 1'b1 || video_en_a !== 1'b0 || h_cfg_a !== H800) begin
            n_fail++; $display("FAIL wrm_in_warmup: got busy %b video_en %b h_cfg %h required 1 0 %h", busy_a, video_en_a, h_cfg_a, H800);
        end
        rstn = 1'b0;
        tick();
        n_checks++; if (h_cfg_a !== H640) begin n_fail++; $display("FAIL wrm_h_cfg: got %h required %h", h_cfg_a, H640); end
        n_checks++; if (v_cfg_a !== V640) begin n_fail++; $display("FAIL wrm_v_cfg: got %h required %h", v_cfg_a, V640); end
        n_checks++; if (cur_mode_a !== VGA_640x480_60) begin n_fail++; $display("FAIL wrm_cur_mode: got %0d required 0", cur_mode_a); end
        n_checks++; if (line_rstn_a !== 1'b0) begin n_fail++; $display("FAIL wrm_line_rstn: got %b required 0", line_rstn_a); end
        n_checks++; if (video_en_a !== 1'b0) begin n_fail++; $display("FAIL wrm_video_en: got %b required 0", video_en_a); end
        rstn = 1'b1;
    endtask

    task automatic test_warmup3();
        int n, nsof, last, early, width_bad, gap_bad;
        logic prev_sof;
        n = 0;
        while (line_rstn_b !== 1'b1 && n < 20) begin tick(); n++; end
        nsof = 0; last = -1; early = 0; width_bad = 0; gap_bad = 0; prev_sof = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (sof_b === 1'b1) begin
                nsof++;
                if (prev_sof) width_bad++;
                if (last >= 0 && i - last != FRAME) gap_bad++;
                last = i;
                if (nsof == 3) begin
                    n_checks++; if (video_en_b !== 1'b1) begin n_fail++; $display("FAIL w3_video_en_third_sof: got %b required 1", video_en_b); end
                end
            end
            if (nsof < 3 && video_en_b !== 1'b0) early++;
            prev_sof = sof_b;
            tick();
        end
        n_checks++; if (nsof != 3) begin n_fail++; $display("FAIL w3_sof_count: got %0d required 3", nsof); end
        n_checks++; if (early != 0) begin n_fail++; $display("FAIL w3_video_en_early: got %0d cycles required 0", early); end
        n_checks++; if (width_bad != 0) begin n_fail++; $display("FAIL w3_sof_width: got %0d wide pulses required 0", width_bad); end
        n_checks++; if (gap_bad != 0) begin n_fail++; $display("FAIL w3_sof_spacing: got %0d bad gaps required 0", gap_bad); end
        n_checks++; if (ready_b !== 1'b1 || busy_b !== 1'b0) begin n_fail++; $display("FAIL w3_run: got ready %b busy %b required 1 0", ready_b, busy_b); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail = 0;
        rstn = 1'b0;
        mode_req_valid = 1'b0;
        mode_req = VGA_640x480_60;
        test_reset();
        test_same_mode();
        test_mode_change();
        test_vbs_request();
        test_unknown_mode();
        test_reset_in_drain();
        test_reset_in_warmup();
        test_warmup3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
